cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the accumulator CPU datapath.
- Sequences the datapath's memory port (PC/IR/ACC/ALU): PC/IR/ACC load strobes, ALU op code, operand source, memory requests with ready handshake.
- Handles external halt requests, HLT, illegal opcodes and memory timeout.
- Sits between the instruction register (opr input) and datapath/memory.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles for mem_ready per access; 0 disables timeout.
- CNT_W, 4, width of wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin/resume execution (level sampled in IDLE/HALT).
- halt  input  1  halt request, honoured at next instruction boundary.
- opr  input  4  opcode from IR, valid from DECODE onward.
- zero  input  1  ACC==0 flag from datapath.
- mem_ready  input  1  memory completes current access this cycle.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request.
- addr_sel  output  1  0=PC, 1=IR operand address.
- ir_ld  output  1  load IR from mem data.
- pc_inc  output  1  PC<=PC+1.
- pc_ld  output  1  PC<=IR operand.
- acc_ld  output  1  ACC<=ALU result.
- alu_src  output  1  ALU B: 0=memory data, 1=IR immediate.
- alu_cont  output  3  000 ADD, 001 SUB, 011 AND, 100 PASS_B.
- busy  output  1  state not IDLE/HALT.
- halted  output  1  in HALT.
- illegal  output  1  sticky: illegal opcode trapped.
- bus_err  output  1  sticky: memory timeout trapped.

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_RD, MEM_WR, EXEC, HALT. Reset -> IDLE; illegal=bus_err=0; wait counter=0.
- All outputs are decoded combinationally from state, opr, mem_ready; all zero in IDLE/HALT except halted; alu_cont=000 when not driven.
- IDLE: start=1 -> FETCH.
- FETCH: mem_rd=1, addr_sel=0; when mem_ready: ir_ld=1, pc_inc=1, -> DECODE.
- DECODE (1 cycle), by opr:
  - 0000 LDA -> MEM_RD, alu PASS_B.
  - 0010 ADD -> MEM_RD, alu ADD.
  - 0011 SUB -> MEM_RD, alu SUB.
  - 0001 STA -> MEM_WR.
  - 1000 ANDI / 1001 ADDI / 1010 SUBI -> EXEC, alu AND/ADD/SUB.
  - 0110 JMP: pc_ld=1 this cycle -> boundary.
  - 0111 NOP -> boundary.
  - 1111 HLT -> HALT.
  - Other -> HALT, illegal<=1.
- MEM_RD: mem_rd=1, addr_sel=1, alu_src=0, alu_cont held; when mem_ready: acc_ld=1 -> boundary.
- MEM_WR: mem_wr=1, addr_sel=1; when mem_ready -> boundary.
- EXEC: alu_src=1, acc_ld=1 -> boundary.
- Boundary: halt=1 -> HALT, else FETCH.
- Requests stay asserted, address stable, until mem_ready sampled high.
- Zero-wait latencies: NOP/JMP 2 cycles; LDA/ADD/SUB/STA/ANDI/ADDI/SUBI 3 cycles.
- Timeout: counter clears on entry to any access state; increments each cycle mem_ready=0. If counter reaches MEM_TIMEOUT with mem_ready=0 -> HALT, bus_err<=1, request deasserted. mem_ready on the same cycle as the limit wins (access completes).
- HALT: halted=1. start=1 and halt=0 -> FETCH, only if illegal=0 and bus_err=0; sticky errors leave only via rst.
- start ignored outside IDLE/HALT; halt ignored outside boundaries. An in-flight memory access always completes.
- rst mid-access: immediate IDLE, all requests drop asynchronously.

Optional Feature:
- Macro SEQ_JZ_EN.
- Defined: opcode 0100 JZ; in DECODE pc_ld=zero, then boundary (2 cycles).
- Undefined: 0100 is illegal -> HALT, illegal=1.

Test Plan:
- rst, start=1, mem_ready=1, opr=0111 -> FETCH,DECODE,FETCH; ir_ld and pc_inc high in cycle 1 only; busy=1.
- opr=0010, mem_ready low 3 cycles in MEM_RD -> mem_rd, addr_sel=1, alu_cont=000 held 4 cycles; acc_ld one cycle with mem_ready.
- opr=1010 -> EXEC cycle alu_src=1, alu_cont=001, acc_ld=1; 3 cycles total.
- halt=1 during STA write wait -> write completes, then HALT, halted=1; start=1, halt=0 -> FETCH.
- opr=0101 -> HALT, illegal=1; start ignored; rst clears illegal. With SEQ_JZ_EN, opr=0100, zero=1 -> pc_ld=1; zero=0 -> pc_ld=0.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=15 -> HALT after 15 wait cycles, bus_err=1, mem_rd=0; mem_ready=1 on the 15th cycle -> no error.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control/handshake bundle between cpu_sequencer and the accumulator datapath
//
// Signals (direction as seen by the sequencer, modport master):
//   in : start, halt, opr[3:0], zero, mem_ready
//   out: mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, acc_ld, alu_src,
//        alu_cont[2:0], busy, halted, illegal, bus_err
// modport slave is the datapath/memory side (directions reversed).
interface cpu_sequencer_if;
    logic       start;
    logic       halt;
    logic [3:0] opr;
    logic       zero;
    logic       mem_ready;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic       acc_ld;
    logic       alu_src;
    logic [2:0] alu_cont;
    logic       busy;
    logic       halted;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  start, halt, opr, zero, mem_ready,
        output mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, acc_ld, alu_src,
               alu_cont, busy, halted, illegal, bus_err
    );

    modport slave (
        output start, halt, opr, zero, mem_ready,
        input  mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, acc_ld, alu_src,
               alu_cont, busy, halted, illegal, bus_err
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute sequencer for the accumulator CPU
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (returns to IDLE, clears sticky errors)
//   bus  - cpu_sequencer_if.master: start/halt/opr/zero/mem_ready in,
//          memory requests, datapath strobes, ALU control and status out
// Parameters:
//   MEM_TIMEOUT - max wait cycles for mem_ready per access (0 disables)
//   CNT_W       - wait counter width, must hold MEM_TIMEOUT
// Optional feature macro: SEQ_JZ_EN adds opcode 0100 JZ (PC load when zero=1);
// without it 0100 traps as illegal.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR, S_EXEC, S_HALT
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'b0000;
    localparam logic [3:0] OP_STA  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_JZ   = 4'b0100;
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_NOP  = 4'b0111;
    localparam logic [3:0] OP_ANDI = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
    // Counter value seen on the last permitted wait cycle of an access.
    localparam logic [CNT_W-1:0] WAIT_LAST = TIMEOUT_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal_q;
    logic             bus_err_q;
    logic [2:0]       alu_op;
    logic             timeout_hit;
    state_t           boundary_next;

`ifndef SEQ_JZ_EN
    logic unused_zero;
    assign unused_zero = bus.zero;
`endif

    always_comb begin
        alu_op = ALU_ADD;
        case (bus.opr)
            OP_LDA:           alu_op = ALU_PASS;
            OP_ADD, OP_ADDI:  alu_op = ALU_ADD;
            OP_SUB, OP_SUBI:  alu_op = ALU_SUB;
            OP_ANDI:          alu_op = ALU_AND;
            default:          alu_op = ALU_ADD;
        endcase
    end

    // A ready on the limit cycle wins over the timeout.
    assign timeout_hit   = TIMEOUT_EN && !bus.mem_ready && (wait_cnt == WAIT_LAST);
    assign boundary_next = bus.halt ? S_HALT : S_FETCH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            // Only a waiting access keeps counting; any other cycle leaves it
            // cleared, so each access state is entered with a zero count.
            wait_cnt <= '0;
            case (state)
                S_IDLE: if (bus.start) state <= S_FETCH;
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (bus.mem_ready) begin
                        state <= (state == S_FETCH) ? S_DECODE : boundary_next;
                    end else if (timeout_hit) begin
                        state     <= S_HALT;
                        bus_err_q <= 1'b1;
                    end else if (TIMEOUT_EN) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    case (bus.opr)
                        OP_LDA, OP_ADD, OP_SUB:    state <= S_MEM_RD;
                        OP_STA:                    state <= S_MEM_WR;
                        OP_ANDI, OP_ADDI, OP_SUBI: state <= S_EXEC;
                        OP_JMP, OP_NOP:            state <= boundary_next;
`ifdef SEQ_JZ_EN
                        OP_JZ:                     state <= boundary_next;
`endif
                        OP_HLT:                    state <= S_HALT;
                        default: begin
                            state     <= S_HALT;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_EXEC: state <= boundary_next;
                S_HALT: begin
                    if (bus.start && !bus.halt && !illegal_q && !bus_err_q)
                        state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the current state so that an asynchronous
    // reset drops every request immediately.
    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.addr_sel = 1'b0;
        bus.ir_ld    = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_ld    = 1'b0;
        bus.acc_ld   = 1'b0;
        bus.alu_src  = 1'b0;
        bus.alu_cont = ALU_ADD;
        case (state)
            S_FETCH: begin
                bus.mem_rd = 1'b1;
                bus.ir_ld  = bus.mem_ready;
                bus.pc_inc = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_cont = alu_op;
                bus.pc_ld    = (bus.opr == OP_JMP);
`ifdef SEQ_JZ_EN
                if (bus.opr == OP_JZ) bus.pc_ld = bus.zero;
`endif
            end
            S_MEM_RD: begin
                bus.mem_rd   = 1'b1;
                bus.addr_sel = 1'b1;
                bus.alu_cont = alu_op;
                bus.acc_ld   = bus.mem_ready;
            end
            S_MEM_WR: begin
                bus.mem_wr   = 1'b1;
                bus.addr_sel = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src  = 1'b1;
                bus.acc_ld   = 1'b1;
                bus.alu_cont = alu_op;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state != S_IDLE) && (state != S_HALT);
    assign bus.halted  = (state == S_HALT);
    assign bus.illegal = illegal_q;
    assign bus.bus_err = bus_err_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    localparam int T = 15;

    // Expected-output bit positions:
    // {mem_rd,mem_wr,addr_sel,ir_ld,pc_inc,pc_ld,acc_ld,alu_src,alu_cont[2:0],busy,halted,illegal,bus_err}
    localparam logic [14:0] MRD   = 15'h4000;
    localparam logic [14:0] MWR   = 15'h2000;
    localparam logic [14:0] ASEL  = 15'h1000;
    localparam logic [14:0] IRLD  = 15'h0800;
    localparam logic [14:0] PCINC = 15'h0400;
    localparam logic [14:0] PCLD  = 15'h0200;
    localparam logic [14:0] ACCLD = 15'h0100;
    localparam logic [14:0] ASRC  = 15'h0080;
    localparam logic [14:0] A_SUB = 15'h0010;
    localparam logic [14:0] A_AND = 15'h0030;
    localparam logic [14:0] A_PAS = 15'h0040;
    localparam logic [14:0] BUSY  = 15'h0008;
    localparam logic [14:0] HLTD  = 15'h0004;
    localparam logic [14:0] ILL   = 15'h0002;
    localparam logic [14:0] BERR  = 15'h0001;
    localparam logic [14:0] NONE  = 15'h0000;
    localparam logic [14:0] FET   = MRD | IRLD | PCINC | BUSY;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if bus();

    cpu_sequencer #(.MEM_TIMEOUT(T), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        s;
        logic        h;
        logic [3:0]  o;
        logic        z;
        logic        mr;
        logic [14:0] exp;
        string       name;
    } vec_t;

    function automatic logic [14:0] outs();
        return {bus.mem_rd, bus.mem_wr, bus.addr_sel, bus.ir_ld, bus.pc_inc, bus.pc_ld,
                bus.acc_ld, bus.alu_src, bus.alu_cont, bus.busy, bus.halted,
                bus.illegal, bus.bus_err};
    endfunction

    function automatic vec_t v(logic s, logic h, logic [3:0] o, logic z, logic mr,
                               logic [14:0] e, string n);
        vec_t r;
        r.s = s; r.h = h; r.o = o; r.z = z; r.mr = mr; r.exp = e; r.name = n;
        return r;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] ro();
        return 4'($urandom);
    endfunction

    // ALU code the opcode table asks for, as a bit mask in the output word.
    function automatic logic [14:0] alu_of(logic [3:0] op);
        case (op)
            4'h0:       return A_PAS;
            4'h3, 4'hA: return A_SUB;
            4'h8:       return A_AND;
            default:    return NONE;
        endcase
    endfunction

    // 0 mem read, 1 mem write, 2 exec, 3 jmp, 4 nop, 5 hlt, 6 jz, 7 illegal
    function automatic int cls(logic [3:0] op);
        case (op)
            4'h0, 4'h2, 4'h3: return 0;
            4'h1:             return 1;
            4'h8, 4'h9, 4'hA: return 2;
            4'h6:             return 3;
            4'h7:             return 4;
            4'hF:             return 5;
`ifdef SEQ_JZ_EN
            4'h4:             return 6;
`endif
            default:          return 7;
        endcase
    endfunction

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic h, input logic [3:0] o, input logic z,
                       input logic mr, input logic [14:0] exp, input string name);
        @(negedge clk);
        bus.start = s; bus.halt = h; bus.opr = o; bus.zero = z; bus.mem_ready = mr;
        #1;
        check(name, outs(), exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0; bus.halt = 1'b0; bus.opr = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        #1;
        check("reset", outs(), NONE);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Plays one instruction starting in FETCH; returns whether it ends in HALT.
    task automatic play_instr(input logic [3:0] op, input int wf, input int wm,
                              input logic hb, output logic to_halt);
        logic        z;
        logic [14:0] a;
        z = rb();
        a = alu_of(op);
        to_halt = hb;
        for (int i = 0; i < wf; i++) cyc(rb(), rb(), ro(), rb(), 1'b0, MRD | BUSY, "r_fetch_wait");
        cyc(rb(), rb(), ro(), rb(), 1'b1, FET, "r_fetch");
        case (cls(op))
            0: begin
                cyc(rb(), rb(), op, z, rb(), BUSY | a, "r_decode_rd");
                for (int i = 0; i < wm; i++) cyc(rb(), rb(), op, z, 1'b0, MRD | ASEL | BUSY | a, "r_rd_wait");
                cyc(rb(), hb, op, z, 1'b1, MRD | ASEL | ACCLD | BUSY | a, "r_rd_done");
            end
            1: begin
                cyc(rb(), rb(), op, z, rb(), BUSY, "r_decode_wr");
                for (int i = 0; i < wm; i++) cyc(rb(), rb(), op, z, 1'b0, MWR | ASEL | BUSY, "r_wr_wait");
                cyc(rb(), hb, op, z, 1'b1, MWR | ASEL | BUSY, "r_wr_done");
            end
            2: begin
                cyc(rb(), rb(), op, z, rb(), BUSY | a, "r_decode_ex");
                cyc(rb(), hb, op, z, rb(), ASRC | ACCLD | BUSY | a, "r_exec");
            end
            3: cyc(rb(), hb, op, z, rb(), BUSY | PCLD, "r_jmp");
            4: cyc(rb(), hb, op, z, rb(), BUSY, "r_nop");
            6: cyc(rb(), hb, op, z, rb(), BUSY | (z ? PCLD : NONE), "r_jz");
            default: begin
                cyc(rb(), rb(), op, z, rb(), BUSY, "r_hlt");
                to_halt = 1'b1;
            end
        endcase
    endtask

    vec_t       tbl[$];
    logic [3:0] legal[$];

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.halt = 1'b0; bus.opr = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        do_reset();

        // NOP, ADD with waits, SUBI, STA with pending halt, resume, LDA
        tbl.push_back(v(1'b1, 1'b0, 4'h7, 1'b0, 1'b1, NONE, "idle_start"));
        tbl.push_back(v(1'b0, 1'b0, 4'h7, 1'b0, 1'b1, FET, "nop_fetch"));
        tbl.push_back(v(1'b0, 1'b0, 4'h7, 1'b0, 1'b1, BUSY, "nop_decode"));
        tbl.push_back(v(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, MRD | BUSY, "fetch_wait"));
        tbl.push_back(v(1'b0, 1'b0, 4'h2, 1'b0, 1'b1, FET, "add_fetch"));
        tbl.push_back(v(1'b0, 1'b0, 4'h2, 1'b0, 1'b0, BUSY, "add_decode"));
        tbl.push_back(v(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, MRD | ASEL | BUSY, "add_wait1"));
        tbl.push_back(v(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, MRD | ASEL | BUSY, "add_wait2"));
        tbl.push_back(v(1'b0, 1'b0, 4'h2, 1'b0, 1'b0, MRD | ASEL | BUSY, "add_wait3"));
        tbl.push_back(v(1'b0, 1'b0, 4'h2, 1'b0, 1'b1, MRD | ASEL | ACCLD | BUSY, "add_done"));
        tbl.push_back(v(1'b0, 1'b0, 4'hA, 1'b0, 1'b1, FET, "subi_fetch"));
        tbl.push_back(v(1'b0, 1'b0, 4'hA, 1'b0, 1'b0, BUSY | A_SUB, "subi_decode"));
        tbl.push_back(v(1'b0, 1'b0, 4'hA, 1'b0, 1'b0, ASRC | ACCLD | A_SUB | BUSY, "subi_exec"));
        tbl.push_back(v(1'b0, 1'b0, 4'h1, 1'b0, 1'b1, FET, "sta_fetch"));
        tbl.push_back(v(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, BUSY, "sta_decode"));
        tbl.push_back(v(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, MWR | ASEL | BUSY, "sta_wait1"));
        tbl.push_back(v(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, MWR | ASEL | BUSY, "sta_wait2"));
        tbl.push_back(v(1'b0, 1'b1, 4'h1, 1'b0, 1'b1, MWR | ASEL | BUSY, "sta_done"));
        tbl.push_back(v(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, HLTD, "halted"));
        tbl.push_back(v(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, HLTD, "halt_hold"));
        tbl.push_back(v(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, HLTD, "resume"));
        tbl.push_back(v(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, FET, "lda_fetch"));
        tbl.push_back(v(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, BUSY | A_PAS, "lda_decode"));
        tbl.push_back(v(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, MRD | ASEL | ACCLD | A_PAS | BUSY, "lda_done"));
        tbl.push_back(v(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, MRD | BUSY, "after_lda"));
        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i].s, tbl[i].h, tbl[i].o, tbl[i].z, tbl[i].mr, tbl[i].exp, tbl[i].name);

        // reset in the middle of an access drops the request at once
        do_reset();

        // illegal opcode traps, start ignored, reset clears it
        cyc(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, NONE, "ill_idle");
        cyc(1'b0, 1'b0, 4'h5, 1'b0, 1'b1, FET, "ill_fetch");
        cyc(1'b0, 1'b0, 4'h5, 1'b0, 1'b0, BUSY, "ill_decode");
        cyc(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, HLTD | ILL, "ill_halt");
        cyc(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, HLTD | ILL, "ill_start_ignored");
        do_reset();

        // opcode 0100
        cyc(1'b1, 1'b0, 4'h4, 1'b1, 1'b0, NONE, "jz_idle");
        cyc(1'b0, 1'b0, 4'h4, 1'b1, 1'b1, FET, "jz_fetch");
`ifdef SEQ_JZ_EN
        cyc(1'b0, 1'b0, 4'h4, 1'b1, 1'b0, BUSY | PCLD, "jz_taken");
        cyc(1'b0, 1'b0, 4'h4, 1'b0, 1'b1, FET, "jz_fetch2");
        cyc(1'b0, 1'b0, 4'h4, 1'b0, 1'b0, BUSY, "jz_not_taken");
        cyc(1'b0, 1'b0, 4'h4, 1'b0, 1'b0, MRD | BUSY, "jz_next_fetch");
`else
        cyc(1'b0, 1'b0, 4'h4, 1'b1, 1'b0, BUSY, "jz_decode");
        cyc(1'b0, 1'b0, 4'h4, 1'b1, 1'b0, HLTD | ILL, "jz_illegal");
`endif
        do_reset();

        // timeout after T wait cycles in FETCH
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, NONE, "to_idle");
        for (int i = 0; i < T; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, MRD | BUSY, "to_wait");
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, HLTD | BERR, "to_halt");
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, HLTD | BERR, "to_start_ignored");
        do_reset();

        // ready on the limit cycle completes the access
        cyc(1'b1, 1'b0, 4'h7, 1'b0, 1'b0, NONE, "lim_idle");
        for (int i = 0; i < T - 1; i++) cyc(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, MRD | BUSY, "lim_wait");
        cyc(1'b0, 1'b0, 4'h7, 1'b0, 1'b1, FET, "lim_done");
        cyc(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, BUSY, "lim_decode");
        do_reset();

        // randomized instruction stream against the instruction-level model
        legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'h6, 4'h7, 4'hF};
`ifdef SEQ_JZ_EN
        legal.push_back(4'h4);
`endif
        cyc(1'b1, rb(), ro(), rb(), rb(), NONE, "r_idle_start");
        for (int n = 0; n < 150; n++) begin
            logic [3:0] op;
            logic       th;
            op = legal[$urandom_range(0, legal.size() - 1)];
            play_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0), th);
            if (th) begin
                for (int k = 0; k < $urandom_range(0, 2); k++)
                    cyc(1'b0, rb(), ro(), rb(), rb(), HLTD, "r_halted");
                cyc(1'b1, 1'b1, ro(), rb(), rb(), HLTD, "r_halt_hold");
                cyc(1'b1, 1'b0, ro(), rb(), rb(), HLTD, "r_resume");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
